reflex_timer: RTL and testbench
===============================

Name: reflex_timer

Overview:
Consumer end of the divided timebase: samples the free-running square wave from the 1 µs divider and treats each rising edge as one time unit ("tick"). Runs one reflex trial per start pulse:
- waits a pseudo-random number of ticks;
- raises the GO stimulus;
- measures ticks until the player's button press.
Reports the result, a false start, or a timeout to the scoring/display logic.

Parameters:
RES_W, 16, width of the tick counters and result.
DELAY_MIN, 1000, minimum pre-GO wait in ticks.
DELAY_RAND_W, 12, random wait addend width; added wait is 0..2^DELAY_RAND_W-1 ticks; must be ≥1.
TIMEOUT, 50000, ticks allowed after GO before timeout; must satisfy 1 ≤ TIMEOUT < 2^RES_W.
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
clk_1us  in  1  divided square wave; each rising edge = 1 tick; asynchronous to this logic for sampling purposes.
start  in  1  single-clk pulse; arms a trial.
btn  in  1  player button, raw level, active-high.
go  out  1  stimulus, high only in GO.
busy  out  1  high in WAIT or GO.
valid  out  1  one-clk pulse on entering DONE, EARLY or TOUT.
done  out  1  sticky; trial ended by a valid press.
early  out  1  sticky; press occurred before GO.
timeout  out  1  sticky; no press within TIMEOUT.
result  out  RES_W  reaction time in ticks; held until next start.

Behaviour:
Reset:
- Async rst clears state to IDLE and all outputs and counters to 0.
- LFSR loads LFSR_SEED.
- Reset asserted mid-trial drops go immediately, with no clock required.

Input conditioning:
- clk_1us passes through a 2-flop synchroniser plus a delay flop.
- tick = sync & ~delayed, one clk wide, 3 clks after the input rises.
- btn is conditioned the same way to give btn_rise. Debounce is handled upstream.

LFSR:
- 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
- Advances every clk regardless of state.
- Never reaches 0.

FSM states: IDLE, WAIT, GO, DONE, EARLY, TOUT.
- IDLE / DONE / EARLY / TOUT: on start, enter WAIT.
  - Load delay_cnt = DELAY_MIN + lfsr[DELAY_RAND_W-1:0].
  - Clear result, done, early, timeout, and meas_cnt.
- WAIT:
  - btn_rise: enter EARLY, early=1, result=0. btn_rise has priority over delay expiry in the same clk.
  - Else on tick: delay_cnt decrements.
  - When tick occurs with delay_cnt==1: enter GO, so go rises the clk after that tick.
  - start is ignored.
- GO: go=1.
  - On tick: meas_cnt++.
  - btn_rise: enter DONE, done=1, result=meas_cnt, i.e. the value before any same-clk increment.
  - Tick with meas_cnt==TIMEOUT-1 and no btn_rise: enter TOUT, timeout=1, result=TIMEOUT.
  - btn_rise in the same clk as the timeout tick: DONE wins, result=TIMEOUT-1.
  - start is ignored.
- Terminal states: go=0, busy=0; outputs held.
- valid pulses exactly once per trial, in the first clk of the terminal state.

Width rules:
- delay_cnt is RES_W wide; DELAY_MIN + 2^DELAY_RAND_W - 1 must fit in it.
- meas_cnt cannot overflow because TIMEOUT bounds it.
- Terminal-state transitions are registered; result, flags and valid change on the same clk edge.

Decomposition:
- Shared package/header holds:
  - state encodings for IDLE, WAIT, GO, DONE, EARLY, TOUT;
  - LFSR width, tap mask 16'hB400, and default seed.
- One natural sub-module: sync_edge. It implements a 2-flop synchroniser plus rising-edge detector, with async active-high rst on clk/rst, and is instantiated twice (clk_1us, btn).
- FSM, counters and LFSR stay in reflex_timer.

Test Plan:
Bench parameters: DELAY_MIN=4, DELAY_RAND_W=2, TIMEOUT=20; clk_1us toggles every 5 clks, so 1 tick = 10 clks.

1. Reset: hold rst, then release -> go, busy, valid, done, early, timeout = 0 and result = 0. Assert rst mid-GO -> go=0 in the same cycle, no clk edge needed; a following start re-arms normally.
2. Normal trial: start, then press btn between ticks 7 and 8 after go rises -> exactly one valid pulse, done=1, result=7, go=0, busy=0.
3. Delay range: run 50 trials with no press -> WAIT duration in ticks is always within [4,7], and at least 2 distinct values are observed.
4. False start: press btn during WAIT -> early=1, result=0, valid once, go never asserted.
5. Timeout: no press -> on the 20th tick after GO, timeout=1, result=20, go=0. Separately, press aligned so btn_rise and the 20th tick land in the same clk -> done=1, timeout=0, result=19.
6. Restart and ignore: start during GO is ignored (meas continues, result as expected). start in DONE begins a new trial with flags cleared and result=0 until the next terminal state.

Source files
------------

// File: rtl/reflex_timer_pkg.sv
// rtl/reflex_timer_pkg.sv - shared state encoding and LFSR constants for reflex_timer
package reflex_timer_pkg;

  // Trial phases; the three terminal states hold their outputs until the next start
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_GO    = 3'd2,
    ST_DONE  = 3'd3,
    ST_EARLY = 3'd4,
    ST_TOUT  = 3'd5
  } state_t;

  // 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam int                LFSR_W            = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // One LFSR step; a nonzero state never maps to zero
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/reflex_timer_sync_edge.sv
// rtl/reflex_timer_sync_edge.sv - 2-flop synchroniser with rising-edge detect
module reflex_timer_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic dly;

  // Two flops to resolve metastability, a third to remember the previous level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      dly  <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  // One-clk pulse for each synchronised 0->1 transition
  assign rise = sync & ~dly;

endmodule

// File: rtl/reflex_timer.sv
// rtl/reflex_timer.sv - reflex trial timer: random wait, GO stimulus, reaction measurement
module reflex_timer
  import reflex_timer_pkg::*;
#(
  parameter int          RES_W        = 16,
  parameter int          DELAY_MIN    = 1000,
  parameter int          DELAY_RAND_W = 12,
  parameter int          TIMEOUT      = 50000,
  parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_1us,
  input  logic             start,
  input  logic             btn,
  output logic             go,
  output logic             busy,
  output logic             valid,
  output logic             done,
  output logic             early,
  output logic             timeout,
  output logic [RES_W-1:0] result
);

  localparam logic [RES_W-1:0] DELAY_BASE = RES_W'(DELAY_MIN);
  localparam logic [RES_W-1:0] MEAS_LAST  = RES_W'(TIMEOUT - 1);
  localparam logic [RES_W-1:0] MEAS_TOUT  = RES_W'(TIMEOUT);
  localparam logic [RES_W-1:0] CNT_ONE    = RES_W'(1);

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [RES_W-1:0]  delay_cnt;
  logic [RES_W-1:0]  meas_cnt;
  logic [RES_W-1:0]  delay_load;
  logic              tick;
  logic              btn_rise;

  reflex_timer_sync_edge u_tick_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (clk_1us),
    .rise (tick)
  );

  reflex_timer_sync_edge u_btn_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (btn),
    .rise (btn_rise)
  );

  // Random part of the wait is the low LFSR bits, zero-extended onto the minimum
  assign delay_load = DELAY_BASE + {{(RES_W - DELAY_RAND_W){1'b0}}, lfsr[DELAY_RAND_W-1:0]};

  // Free-running LFSR so the sampled delay depends on when start arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Trial FSM with its counters and registered outputs; terminal transitions update result, flags and valid together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      go        <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      done      <= 1'b0;
      early     <= 1'b0;
      timeout   <= 1'b0;
      result    <= '0;
      delay_cnt <= '0;
      meas_cnt  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_EARLY, ST_TOUT: begin
          if (start) begin
            state     <= ST_WAIT;
            busy      <= 1'b1;
            delay_cnt <= delay_load;
            meas_cnt  <= '0;
            result    <= '0;
            done      <= 1'b0;
            early     <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        ST_WAIT: begin
          // A press before GO beats a delay expiry in the same clk
          if (btn_rise) begin
            state  <= ST_EARLY;
            early  <= 1'b1;
            result <= '0;
            busy   <= 1'b0;
            valid  <= 1'b1;
          end else if (tick) begin
            delay_cnt <= delay_cnt - CNT_ONE;
            if (delay_cnt == CNT_ONE || delay_cnt == '0) begin
              state <= ST_GO;
              go    <= 1'b1;
            end
          end
        end
        ST_GO: begin
          if (tick) begin
            meas_cnt <= meas_cnt + CNT_ONE;
          end
          // The press reports the count before any same-clk tick, so it wins over the timeout tick
          if (btn_rise) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            result <= meas_cnt;
            go     <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b1;
          end else if (tick && meas_cnt == MEAS_LAST) begin
            state   <= ST_TOUT;
            timeout <= 1'b1;
            result  <= MEAS_TOUT;
            go      <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          go    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reflex_timer.sv
// tb/tb_reflex_timer.sv - self-checking bench for reflex_timer
module tb_reflex_timer;

  localparam int RES_W = 16;
  localparam int DMIN  = 4;
  localparam int DRW   = 2;
  localparam int TMO   = 20;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             clk_1us = 1'b0;
  logic             start   = 1'b0;
  logic             btn     = 1'b0;
  logic             go;
  logic             busy;
  logic             valid;
  logic             done;
  logic             early;
  logic             timeout;
  logic [RES_W-1:0] result;

  int tests     = 0;
  int fails     = 0;
  int rise_cnt  = 0;
  int valid_cnt = 0;
  int go_cycles = 0;
  int s_rise    = 0;

  reflex_timer #(
    .RES_W        (RES_W),
    .DELAY_MIN    (DMIN),
    .DELAY_RAND_W (DRW),
    .TIMEOUT      (TMO),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_1us (clk_1us),
    .start   (start),
    .btn     (btn),
    .go      (go),
    .busy    (busy),
    .valid   (valid),
    .done    (done),
    .early   (early),
    .timeout (timeout),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Timebase: toggles every 5 clks, one tick per 10 clks
  initial begin
    forever begin
      repeat (5) @(negedge clk);
      clk_1us = ~clk_1us;
      if (clk_1us) rise_cnt++;
    end
  end

  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt++;
    if (go === 1'b1) go_cycles++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start just after a timebase fall so no tick races the start pulse
  task automatic do_start();
    @(negedge clk_1us);
    @(negedge clk);
    s_rise = rise_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_go(output int wticks, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (go === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    wticks = rise_cnt - s_rise;
  endtask

  // Press k ticks from now: mid-tick, or on the same edge as tick k when aligned
  task automatic press_after_ticks(input int k, input bit aligned);
    for (int i = 0; i < k; i++) @(posedge clk_1us);
    if (!aligned) repeat (2) @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit ended;
    ended = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ended = 1'b1;
        break;
      end
    end
    check({tag, "_ended"}, int'(ended), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_end(input string tag, input int e_done, input int e_early,
                           input int e_tout, input int e_res, input int v0);
    check({tag, "_done"},    int'(done),    e_done);
    check({tag, "_early"},   int'(early),   e_early);
    check({tag, "_timeout"}, int'(timeout), e_tout);
    check({tag, "_result"},  int'(result),  e_res);
    check({tag, "_go"},      int'(go),      0);
    check({tag, "_busy"},    int'(busy),    0);
    check({tag, "_valid1"},  valid_cnt - v0, 1);
  endtask

  // Reference outcome from a press between tick k and k+1 (or on tick k if aligned) after GO
  function automatic void model(input int k, input bit aligned, input bit pressed,
                                output int e_done, output int e_tout, output int e_res);
    int last_tick;
    last_tick = aligned ? k - 1 : k;
    if (pressed && last_tick < TMO) begin
      e_done = 1; e_tout = 0; e_res = last_tick;
    end else begin
      e_done = 0; e_tout = 1; e_res = TMO;
    end
  endfunction

  initial begin
    int  w;
    bit  ok;
    int  v0;
    int  g0;
    int  mask;
    int  distinct;
    int  kind;
    int  k;
    int  e_done;
    int  e_tout;
    int  e_res;

    // Reset state
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_go", int'(go), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_early", int'(early), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_result", int'(result), 0);

    // Normal trial: press between ticks 7 and 8 after GO
    v0 = valid_cnt;
    do_start();
    @(negedge clk);
    check("arm_busy", int'(busy), 1);
    wait_go(w, ok);
    check("norm_go_seen", int'(ok), 1);
    press_after_ticks(7, 1'b0);
    wait_end("norm");
    check_end("norm", 1, 0, 0, 7, v0);

    // Async reset mid-GO drops go without a clock edge
    do_start();
    wait_go(w, ok);
    check("rstgo_go_seen", int'(ok), 1);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rstgo_go_async", int'(go), 0);
    check("rstgo_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    v0 = valid_cnt;
    do_start();
    wait_go(w, ok);
    check("rearm_go_seen", int'(ok), 1);
    press_after_ticks(3, 1'b0);
    wait_end("rearm");
    check_end("rearm", 1, 0, 0, 3, v0);

    // Delay range over 50 trials with no press
    mask = 0;
    for (int t = 0; t < 50; t++) begin
      do_start();
      wait_go(w, ok);
      check("delay_in_range", int'(ok && w >= DMIN && w <= DMIN + (1 << DRW) - 1), 1);
      if (w >= 0 && w < 32) mask = mask | (1 << w);
      wait_end("dly");
      check("dly_timeout", int'(timeout), 1);
    end
    distinct = $countones(mask);
    check("delay_distinct", int'(distinct >= 2), 1);

    // False start
    v0 = valid_cnt;
    g0 = go_cycles;
    do_start();
    press_after_ticks(1, 1'b0);
    wait_end("early");
    check_end("early", 0, 1, 0, 0, v0);
    check("early_no_go", go_cycles - g0, 0);

    // Timeout with no press
    v0 = valid_cnt;
    do_start();
    wait_go(w, ok);
    check("tout_go_seen", int'(ok), 1);
    wait_end("tout");
    check_end("tout", 0, 0, 1, TMO, v0);

    // Press on the same clk as the final tick: DONE wins
    v0 = valid_cnt;
    do_start();
    wait_go(w, ok);
    press_after_ticks(TMO, 1'b1);
    wait_end("race");
    check_end("race", 1, 0, 0, TMO - 1, v0);

    // Start during GO is ignored
    v0 = valid_cnt;
    do_start();
    wait_go(w, ok);
    for (int i = 0; i < 2; i++) @(posedge clk_1us);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_go_still", int'(go), 1);
    press_after_ticks(4, 1'b0);
    wait_end("ign");
    check_end("ign", 1, 0, 0, 6, v0);

    // Start in DONE clears flags and result
    v0 = valid_cnt;
    do_start();
    @(negedge clk);
    check("redo_done_clr", int'(done), 0);
    check("redo_result_clr", int'(result), 0);
    check("redo_busy", int'(busy), 1);
    wait_go(w, ok);
    check("redo_result_go", int'(result), 0);
    press_after_ticks(2, 1'b0);
    wait_end("redo");
    check_end("redo", 1, 0, 0, 2, v0);

    // Randomised trials against the outcome model
    for (int t = 0; t < 10; t++) begin
      kind = int'($urandom_range(0, 3));
      v0 = valid_cnt;
      g0 = go_cycles;
      do_start();
      if (kind == 0) begin
        press_after_ticks(int'($urandom_range(0, DMIN - 2)), 1'b0);
        wait_end("rnd_early");
        check_end("rnd_early", 0, 1, 0, 0, v0);
        check("rnd_early_no_go", go_cycles - g0, 0);
      end else begin
        wait_go(w, ok);
        check("rnd_go_seen", int'(ok), 1);
        if (kind == 1) begin
          k = int'($urandom_range(1, TMO + 4));
          press_after_ticks(k, 1'b0);
          model(k, 1'b0, 1'b1, e_done, e_tout, e_res);
        end else if (kind == 2) begin
          k = int'($urandom_range(1, TMO));
          press_after_ticks(k, 1'b1);
          model(k, 1'b1, 1'b1, e_done, e_tout, e_res);
        end else begin
          model(0, 1'b0, 1'b0, e_done, e_tout, e_res);
        end
        wait_end("rnd");
        check_end("rnd", e_done, 0, e_tout, e_res, v0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
